// File: rtl/dma_desc_scheduler.sv
// dma_desc_scheduler
//   Shares one DMA engine among NUM_CH requesters. Each requester offers a
//   (src, dst, len) descriptor with valid/ready. A round-robin grant picks one
//   descriptor, which is latched and driven onto the engine controls. The
//   scheduler then waits for the engine's completion pulse and returns a
//   one-cycle done to the owning requester.
//
//   Optional feature: define DMA_SCHED_TIMEOUT_EN to abort a RUN that lasts
//   TIMEOUT cycles. The aborted transfer is reported with done_err=1.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   req_valid/ready per-channel handshake; ready is one-hot, combinational
//   req_src/dst/len packed descriptors, channel i at [i*W +: W]
//   done_valid/err  one-hot completion pulse; err = timed out
//   dma_start/src/dst/len  engine controls (registered)
//   dma_done        engine completion pulse, honoured only in RUN
//   busy, cur_ch    scheduler occupied / channel owning the engine
module dma_desc_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH*ADDR_W-1:0]   req_src,
  input  logic [NUM_CH*ADDR_W-1:0]   req_dst,
  input  logic [NUM_CH*LEN_W-1:0]    req_len,
  output logic [NUM_CH-1:0]          done_valid,
  output logic [NUM_CH-1:0]          done_err,
  output logic                       dma_start,
  output logic [ADDR_W-1:0]          dma_src,
  output logic [ADDR_W-1:0]          dma_dst,
  output logic [LEN_W-1:0]           dma_len,
  input  logic                       dma_done,
  output logic                       busy,
  output logic [$clog2(NUM_CH)-1:0]  cur_ch
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;

  logic                grant_found_s;
  logic [CH_W-1:0]     grant_idx_s;
  logic [CH_W:0]       sum_s;
  logic [LEN_W-1:0]    grant_len_s;

`ifdef DMA_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]       timer_q, timer_d;
  logic                err_q, err_d;
`else
  // TIMEOUT only matters when the timeout feature is built in.
  logic                unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT;
`endif

  // Round-robin search: first valid channel at ptr, ptr+1, ... mod NUM_CH.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    sum_s         = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_s = {1'b0, ptr_q} + (CH_W+1)'(k);
      if (sum_s >= (CH_W+1)'(NUM_CH)) begin
        sum_s = sum_s - (CH_W+1)'(NUM_CH);
      end else begin
        sum_s = sum_s;
      end
      if (!grant_found_s && req_valid[sum_s[CH_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = sum_s[CH_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  assign grant_len_s = req_len[int'(grant_idx_s)*LEN_W +: LEN_W];

  // Next-state logic: accept in IDLE, wait for engine in RUN, report in DONE.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_ch_d = cur_ch_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
`ifdef DMA_SCHED_TIMEOUT_EN
    timer_d  = timer_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          cur_ch_d = grant_idx_s;
          src_d    = req_src[int'(grant_idx_s)*ADDR_W +: ADDR_W];
          dst_d    = req_dst[int'(grant_idx_s)*ADDR_W +: ADDR_W];
          len_d    = grant_len_s;
          // A zero-length descriptor completes without touching the engine.
          state_d  = (grant_len_s != '0) ? ST_RUN : ST_DONE;
`ifdef DMA_SCHED_TIMEOUT_EN
          timer_d  = '0;
          err_d    = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Completion beats expiry when both land in the same cycle.
        if (dma_done) begin
          state_d = ST_DONE;
`ifdef DMA_SCHED_TIMEOUT_EN
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
`else
        end else begin
          state_d = ST_RUN;
`endif
        end
      end
      ST_DONE: begin
        if (cur_ch_q == CH_W'(NUM_CH - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = cur_ch_q + CH_W'(1);
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cur_ch_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
      timer_q  <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cur_ch_q <= cur_ch_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
`ifdef DMA_SCHED_TIMEOUT_EN
      timer_q  <= timer_d;
      err_q    <= err_d;
`endif
    end
  end

  // Accept strobe to the granted requester; masked while reset is applied.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && grant_found_s && !rst) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Completion pulse to the owning requester.
  always_comb begin
    done_valid = '0;
    done_err   = '0;
    if (state_q == ST_DONE) begin
      done_valid[cur_ch_q] = 1'b1;
`ifdef DMA_SCHED_TIMEOUT_EN
      done_err[cur_ch_q]   = err_q;
`endif
    end else begin
      done_valid = '0;
    end
  end

  assign dma_start = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign dma_src   = src_q;
  assign dma_dst   = dst_q;
  assign dma_len   = len_q;
  assign cur_ch    = cur_ch_q;

endmodule
